// File: rtl/aura_pkg.sv
// Shared types for the attention datapath: vector element types, tile
// constants and the pair tag carried from the scheduler to dot_product.
// Tag index fields are sized for the largest supported tile (64x64).
package aura_pkg;

  localparam int DK        = 4;  // elements per Q/K/V vector
  localparam int INT_WIDTH = 8;  // bits per element

  localparam int TAG_QA_W  = 6;  // Q row index width carried in the tag
  localparam int TAG_KA_W  = 6;  // K row index width carried in the tag

  typedef logic [DK-1:0][INT_WIDTH-1:0] Q_VECTOR_T;
  typedef logic [DK-1:0][INT_WIDTH-1:0] K_VECTOR_T;
  typedef logic [DK-1:0][INT_WIDTH-1:0] V_VECTOR_T;

  // Row-boundary markers let online softmax reset at first_k and commit at last_k.
  typedef struct packed {
    logic [TAG_QA_W-1:0] q_idx;
    logic [TAG_KA_W-1:0] k_idx;
    logic                first_k;
    logic                last_k;
    logic                last_q;
  } SCHED_TAG_T;

endpackage

// File: rtl/sched_skid_fifo.sv
// Two-entry FIFO holding returned Q/K/V data plus its tag for the scheduler.
// Latency: push visible at head the cycle after the push; head is zero when empty.
// Backpressure: none internally; the caller's credit rule guarantees no push when full.
// Ports: clk, rst (sync, active-high), push/push_dat, pop, count (0..2), head.
module sched_skid_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  // Zero head when empty so downstream outputs read 0 outside valid pairs.
  assign head = (count != 2'd0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/qk_pair_scheduler.sv
// Walks every (Q row, K/V row) pair of a tile, reads both buffers and emits tagged pairs.
// Latency: start to first vld_out is 3 cycles; one pair per cycle when rdy_in stays high.
// Backpressure: valid/ready on the output; a 2-credit loop stops reads when the FIFO would fill.
// Ports: clk, rst (sync, active-high), start + cfg_q_rows/cfg_k_rows, busy, done,
//   Q and K/V read ports (data one cycle after enable), vld_out/rdy_in, q/k/v_out, tag_out.
// Build option: QK_SCHED_CAUSAL_MASK_EN limits row i to columns j <= i.
module qk_pair_scheduler
  import aura_pkg::*;
#(
  parameter int MAX_Q = 64,
  parameter int MAX_K = 64,
  parameter int QA_W  = $clog2(MAX_Q),
  parameter int KA_W  = $clog2(MAX_K)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [QA_W:0]   cfg_q_rows,
  input  logic [KA_W:0]   cfg_k_rows,
  output logic            busy,
  output logic            done,
  output logic            q_rd_en,
  output logic [QA_W-1:0] q_rd_addr,
  output logic            kv_rd_en,
  output logic [KA_W-1:0] kv_rd_addr,
  input  Q_VECTOR_T       q_rd_data,
  input  K_VECTOR_T       k_rd_data,
  input  V_VECTOR_T       v_rd_data,
  output logic            vld_out,
  input  logic            rdy_in,
  output Q_VECTOR_T       q_out,
  output K_VECTOR_T       k_out,
  output V_VECTOR_T       v_out,
  output SCHED_TAG_T      tag_out
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam int CW     = ((QA_W > KA_W) ? QA_W : KA_W) + 1;
  localparam int PAIR_W = $bits(Q_VECTOR_T) + $bits(K_VECTOR_T) + $bits(V_VECTOR_T)
                        + $bits(SCHED_TAG_T);
  localparam logic [QA_W:0] Q_ONE = 1;
  localparam logic [KA_W:0] K_ONE = 1;

  state_t            state, nxt_state;
  logic [QA_W:0]     q_rows_r;
  logic [KA_W:0]     k_rows_r;
  logic [QA_W-1:0]   i;
  logic [KA_W-1:0]   j;
  logic              inflight;
  SCHED_TAG_T        inflight_tag;

  logic [QA_W:0]     q_last;
  logic [KA_W:0]     k_last;
  logic [KA_W-1:0]   last_j;
  logic              last_k;
  logic              last_q;
  logic              pop;
  logic              credit_ok;
  logic              issue;
  SCHED_TAG_T        issue_tag;
  logic [1:0]        fifo_count;
  logic [PAIR_W-1:0] fifo_head;

  // Row bounds, tags and the issue decision for the current (i, j).
  always_comb begin
    q_last = q_rows_r - Q_ONE;
    k_last = k_rows_r - K_ONE;
`ifdef QK_SCHED_CAUSAL_MASK_EN
    if (CW'(i) < CW'(k_last)) last_j = KA_W'(i);
    else                      last_j = k_last[KA_W-1:0];
`else
    last_j = k_last[KA_W-1:0];
`endif
    last_k = (j == last_j);
    last_q = (CW'(i) == CW'(q_last)) && last_k;
    pop    = (fifo_count != 2'd0) && rdy_in;
    // occupancy + inflight - pop < 2, rearranged to stay non-negative.
    credit_ok = ({1'b0, fifo_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
    issue     = !rst && (state == S_RUN) && credit_ok;
    issue_tag.q_idx   = TAG_QA_W'(i);
    issue_tag.k_idx   = TAG_KA_W'(j);
    issue_tag.first_k = (j == '0);
    issue_tag.last_k  = last_k;
    issue_tag.last_q  = last_q;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt_state;
  end

  // Next-state logic. An empty tile passes through DRAIN, which exits at once
  // because nothing is in flight; this keeps done two cycles after start.
  always_comb begin
    nxt_state = state;
    case (state)
      S_IDLE:  if (start) nxt_state = ((cfg_q_rows == '0) || (cfg_k_rows == '0)) ? S_DRAIN : S_RUN;
      S_RUN:   if (issue && last_q) nxt_state = S_DRAIN;
      S_DRAIN: if (!inflight && (fifo_count == 2'd0)) nxt_state = S_DONE;
      S_DONE:  nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
    q_rd_en    = issue;
    kv_rd_en   = issue;
    q_rd_addr  = issue ? i : '0;
    kv_rd_addr = issue ? j : '0;
    vld_out    = (fifo_count != 2'd0);
    {q_out, k_out, v_out, tag_out} = fifo_head;
  end

  // Tile counters and the single in-flight read marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_rows_r     <= '0;
      k_rows_r     <= '0;
      i            <= '0;
      j            <= '0;
      inflight     <= 1'b0;
      inflight_tag <= '0;
    end else begin
      inflight <= issue;
      if (issue) inflight_tag <= issue_tag;
      if ((state == S_IDLE) && start) begin
        q_rows_r <= cfg_q_rows;
        k_rows_r <= cfg_k_rows;
        i        <= '0;
        j        <= '0;
      end else if (issue) begin
        if (last_k) begin
          j <= '0;
          i <= i + QA_W'(1);
        end else begin
          j <= j + KA_W'(1);
        end
      end
    end
  end

  // Read data lands one cycle after issue; only a recorded in-flight read is
  // captured, so data returning after a reset is dropped.
  sched_skid_fifo #(.W(PAIR_W)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight),
    .push_dat ({q_rd_data, k_rd_data, v_rd_data, inflight_tag}),
    .pop      (pop),
    .count    (fifo_count),
    .head     (fifo_head)
  );

endmodule

// File: tb/tb_qk_pair_scheduler.sv
// Directed bench for qk_pair_scheduler: buffer model, pair scoreboard, stall
// stability and FIFO occupancy monitor, one summary line at the end.
module tb_qk_pair_scheduler;
  import aura_pkg::*;

  localparam int QA_W = 6;
  localparam int KA_W = 6;

  typedef struct packed {
    SCHED_TAG_T tag;
    Q_VECTOR_T  q;
    K_VECTOR_T  k;
    V_VECTOR_T  v;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [QA_W:0]   cfg_q_rows = '0;
  logic [KA_W:0]   cfg_k_rows = '0;
  logic            busy, done;
  logic            q_rd_en, kv_rd_en;
  logic [QA_W-1:0] q_rd_addr;
  logic [KA_W-1:0] kv_rd_addr;
  Q_VECTOR_T       q_rd_data = '0;
  K_VECTOR_T       k_rd_data = '0;
  V_VECTOR_T       v_rd_data = '0;
  logic            vld_out;
  logic            rdy_in = 1'b1;
  Q_VECTOR_T       q_out;
  K_VECTOR_T       k_out;
  V_VECTOR_T       v_out;
  SCHED_TAG_T      tag_out;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_pop_cyc = 0;
  int   t0 = 0;
  int   dc = 0;
  bit   rand_rdy = 1'b0;
  bit   en_seen = 1'b0;
  exp_t sb[$];

  qk_pair_scheduler #(.MAX_Q(64), .MAX_K(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_q_rows (cfg_q_rows),
    .cfg_k_rows (cfg_k_rows),
    .busy       (busy),
    .done       (done),
    .q_rd_en    (q_rd_en),
    .q_rd_addr  (q_rd_addr),
    .kv_rd_en   (kv_rd_en),
    .kv_rd_addr (kv_rd_addr),
    .q_rd_data  (q_rd_data),
    .k_rd_data  (k_rd_data),
    .v_rd_data  (v_rd_data),
    .vld_out    (vld_out),
    .rdy_in     (rdy_in),
    .q_out      (q_out),
    .k_out      (k_out),
    .v_out      (v_out),
    .tag_out    (tag_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic Q_VECTOR_T qv(int r);
    Q_VECTOR_T x;
    for (int e = 0; e < DK; e++) x[e] = 8'(r * 16 + e + 1);
    return x;
  endfunction
  function automatic K_VECTOR_T kv(int r);
    K_VECTOR_T x;
    for (int e = 0; e < DK; e++) x[e] = 8'(128 + r * 4 + e);
    return x;
  endfunction
  function automatic V_VECTOR_T vv(int r);
    V_VECTOR_T x;
    for (int e = 0; e < DK; e++) x[e] = 8'(64 + r * 8 + e);
    return x;
  endfunction

  // Tile buffer model: one-cycle read latency.
  always @(posedge clk) begin
    if (q_rd_en) q_rd_data <= qv(int'(q_rd_addr));
    if (kv_rd_en) begin
      k_rd_data <= kv(int'(kv_rd_addr));
      v_rd_data <= vv(int'(kv_rd_addr));
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) rdy_in = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected pair sequence for an nq x nk tile, in row-major order.
  task automatic push_tile(input int nq, input int nk);
    exp_t e;
    int   jmax;
    for (int r = 0; r < nq; r++) begin
`ifdef QK_SCHED_CAUSAL_MASK_EN
      jmax = (r < nk - 1) ? r : nk - 1;
`else
      jmax = nk - 1;
`endif
      for (int c = 0; c <= jmax; c++) begin
        e.tag.q_idx   = TAG_QA_W'(r);
        e.tag.k_idx   = TAG_KA_W'(c);
        e.tag.first_k = (c == 0);
        e.tag.last_k  = (c == jmax);
        e.tag.last_q  = (r == nq - 1) && (c == jmax);
        e.q = qv(r);
        e.k = kv(c);
        e.v = vv(c);
        sb.push_back(e);
      end
    end
  endtask

  // Drives start for one cycle; t0 is the start cycle. Returns at cycle t0+1.
  task automatic do_start(input int nq, input int nk, input bit expect_pairs);
    @(posedge clk); #1;
    t0 = cyc;
    cfg_q_rows = 7'(nq);
    cfg_k_rows = 7'(nk);
    start = 1'b1;
    if (expect_pairs) push_tile(nq, nk);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int done_cyc);
    done_cyc = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
    end
    chk("done_seen", 128'(done), 128'(1));
  endtask

  // Scoreboard, stall stability and occupancy monitor.
  logic       prev_stall = 1'b0;
  logic [95:0] prev_dat = '0;
  SCHED_TAG_T prev_tag = '0;
  always @(negedge clk) begin
    if (q_rd_en || kv_rd_en) en_seen = 1'b1;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_vld", 128'(vld_out), 128'(1));
        chk("stall_dat", 128'({q_out, k_out, v_out}), 128'(prev_dat));
        chk("stall_tag", 128'(tag_out), 128'(prev_tag));
      end
      if (vld_out) chk("fifo_occ_le2", 128'(dut.u_fifo.count <= 2'd2), 128'(1));
      if (vld_out && rdy_in) begin
        last_pop_cyc = cyc;
        if (sb.size() == 0) begin
          chk("sb_extra_pair", 128'(tag_out), 128'(0) - 128'(1));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("pair_tag", 128'(tag_out), 128'(e.tag));
          chk("pair_dat", 128'({q_out, k_out, v_out}), 128'({e.q, e.k, e.v}));
        end
      end
      prev_stall = vld_out && !rdy_in;
      prev_dat   = {q_out, k_out, v_out};
      prev_tag   = tag_out;
    end
  end

  initial begin
    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 128'(busy), 0);
    chk("rst_done", 128'(done), 0);
    chk("rst_rd_en", 128'({q_rd_en, kv_rd_en}), 0);
    chk("rst_addr", 128'({q_rd_addr, kv_rd_addr}), 0);
    chk("rst_vld", 128'(vld_out), 0);
    chk("rst_outs", 128'({q_out, k_out, v_out, tag_out}), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 2x3 tile with rdy_in high: latency, order, tags, done timing.
    do_start(2, 3, 1'b1);
    @(negedge clk);
    chk("c1_busy", 128'(busy), 128'(1));
    chk("c1_rd_en", 128'({q_rd_en, kv_rd_en}), 128'(2'b11));
    chk("c1_addr", 128'({q_rd_addr, kv_rd_addr}), 0);
    @(negedge clk);
    chk("c2_vld", 128'(vld_out), 0);
    @(negedge clk);
    chk("c3_vld", 128'(vld_out), 128'(1));
    wait_done(50, dc);
    chk("t23_done_lat", 128'(dc - last_pop_cyc), 128'(2));
    chk("t23_sb_empty", 128'(sb.size()), 0);
    @(negedge clk);
    chk("t23_busy_drop", 128'(busy), 0);

    // 4x4 tile with random backpressure.
    rand_rdy = 1'b1;
    do_start(4, 4, 1'b1);
    wait_done(400, dc);
    rand_rdy = 1'b0;
    rdy_in = 1'b1;
    chk("t44_done_lat", 128'(dc - last_pop_cyc), 128'(2));
    chk("t44_sb_empty", 128'(sb.size()), 0);

    // Zero Q rows: no reads, done in cycle 2.
    repeat (2) @(posedge clk);
    en_seen = 1'b0;
    do_start(0, 3, 1'b0);
    @(negedge clk);
    chk("z_c1_done", 128'(done), 0);
    @(negedge clk);
    chk("z_c2_done", 128'(done), 128'(1));
    chk("z_c2_cyc", 128'(cyc - t0), 128'(2));
    @(negedge clk);
    chk("z_busy_drop", 128'(busy), 0);
    chk("z_no_reads", 128'(en_seen), 0);

    // start reasserted mid-tile is ignored.
    do_start(2, 3, 1'b1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    cfg_q_rows = 7'd1;
    cfg_k_rows = 7'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(50, dc);
    chk("rs_sb_empty", 128'(sb.size()), 0);
    repeat (3) @(negedge clk);
    chk("rs_idle", 128'({busy, vld_out}), 0);

    // Reset in the middle of a 3x3 tile, then a 1x1 tile.
    do_start(3, 3, 1'b1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mr_busy_done", 128'({busy, done}), 0);
    chk("mr_rd", 128'({q_rd_en, kv_rd_en, q_rd_addr, kv_rd_addr}), 0);
    chk("mr_outs", 128'({vld_out, q_out, k_out, v_out, tag_out}), 0);
    @(negedge clk);
    chk("mr_stale_drop", 128'(vld_out), 0);
    do_start(1, 1, 1'b1);
    wait_done(50, dc);
    chk("mr_1x1_sb_empty", 128'(sb.size()), 0);

    // 3x3 tile (causal build delivers the lower triangle only).
    do_start(3, 3, 1'b1);
    wait_done(100, dc);
    chk("t33_sb_empty", 128'(sb.size()), 0);
    repeat (4) @(negedge clk);
    chk("t33_idle", 128'({busy, vld_out}), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
